// File: rtl/tick_led_pkg.sv
// Shared types and constants for the tick-driven LED sequencer.
// Build option TICK_DEBOUNCE_EN (see tick_sync_edge) does not affect this package.
package tick_led_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_OFF    = 2'd3
    } led_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronises the asynchronous tick, optionally debounces it (TICK_DEBOUNCE_EN),
// and turns each rising edge of the resulting level into a one-clk step pulse.
module tick_sync_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic step
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("tick_sync_edge: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("tick_sync_edge: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   level;
    logic                   level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef TICK_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] stable_cnt;
    logic          level_q;

    // The filtered level only follows sync_out after it has disagreed for
    // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_out == level_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_q    <= sync_out;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

    assign level = level_q;
`else
    assign level = sync_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign step = level & ~level_d;

endmodule

// File: rtl/tick_led_sequencer.sv
// Steps an N-LED pattern (chase, bounce, fill, off) on each accepted tick edge.
// Define TICK_DEBOUNCE_EN to add a level debounce filter in front of edge detection.
module tick_led_sequencer
    import tick_led_pkg::*;
#(
    parameter int NUM_LEDS        = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick_in,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic                        dir,
    output logic [NUM_LEDS-1:0]         led,
    output logic [$clog2(NUM_LEDS)-1:0] pos,
    output logic                        wrap_pulse
);

    localparam int PW = $clog2(NUM_LEDS);
    localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);

    if (NUM_LEDS < 2 || NUM_LEDS > 32) begin : g_bad_leds
        $error("tick_led_sequencer: NUM_LEDS must be in 2..32");
    end

    led_mode_t             mode_i;
    led_mode_t             mode_q;
    logic                  step;
    logic                  bounce_dir;
    logic                  bounce_dir_nxt;
    logic [PW-1:0]         pos_nxt;
    logic                  wrap_nxt;
    logic [NUM_LEDS-1:0]   led_nxt;

    assign mode_i = led_mode_t'(mode);

    tick_sync_edge #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_in (tick_in),
        .step    (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos        <= '0;
            bounce_dir <= DIR_UP;
            mode_q     <= MODE_CHASE;
            led        <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            pos        <= pos_nxt;
            bounce_dir <= bounce_dir_nxt;
            mode_q     <= mode_i;
            led        <= led_nxt;
            wrap_pulse <= wrap_nxt;
        end
    end

    // Bounce direction is seeded from dir on the cycle bounce is entered, so a step
    // arriving in that same cycle already travels in the requested direction.
    always_comb begin
        pos_nxt        = pos;
        wrap_nxt       = 1'b0;
        bounce_dir_nxt = (mode_i == MODE_BOUNCE && mode_q != MODE_BOUNCE) ? dir : bounce_dir;
        if (step && enable) begin
            case (mode_i)
                MODE_CHASE, MODE_FILL: begin
                    if (dir == DIR_UP) begin
                        if (pos == LAST) begin
                            pos_nxt  = '0;
                            wrap_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_nxt  = LAST;
                            wrap_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos - PW'(1);
                        end
                    end
                end
                MODE_BOUNCE: begin
                    if (bounce_dir_nxt == DIR_UP) begin
                        if (pos == LAST) begin
                            pos_nxt        = pos - PW'(1);
                            bounce_dir_nxt = DIR_DOWN;
                            wrap_nxt       = 1'b1;
                        end else begin
                            pos_nxt = pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_nxt        = PW'(1);
                            bounce_dir_nxt = DIR_UP;
                            wrap_nxt       = 1'b1;
                        end else begin
                            pos_nxt = pos - PW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        led_nxt = '0;
        case (mode_i)
            MODE_CHASE, MODE_BOUNCE: led_nxt[pos_nxt] = 1'b1;
            MODE_FILL: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    led_nxt[i] = (i <= int'(pos_nxt));
                end
            end
            default: led_nxt = '0;
        endcase
    end

endmodule

// File: tb/tb_tick_led_sequencer.sv
// Directed self-checking bench for tick_led_sequencer with NUM_LEDS=5.
// With TICK_DEBOUNCE_EN defined, ticks are held longer and the glitch-filter steps run.
module tb_tick_led_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick_in;
    logic       enable;
    logic [1:0] mode;
    logic       dir;
    logic [4:0] led;
    logic [2:0] pos;
    logic       wrap_pulse;

    int tests = 0;
    int fails = 0;
    int wrap_total = 0;
    int wrap_base = 0;

`ifdef TICK_DEBOUNCE_EN
    localparam int HOLD = 24;
`else
    localparam int HOLD = 4;
`endif

    tick_led_sequencer #(
        .NUM_LEDS        (5),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .enable     (enable),
        .mode       (mode),
        .dir        (dir),
        .led        (led),
        .pos        (pos),
        .wrap_pulse (wrap_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every clock cycle in which wrap_pulse is high.
    always @(posedge clk) begin
        if (wrap_pulse === 1'b1) wrap_total++;
    end

    task automatic applyStimulus(input int high_cycles, input int low_cycles);
        tick_in = 1'b1;
        repeat (high_cycles) @(negedge clk);
        tick_in = 1'b0;
        repeat (low_cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] exp_led,
                               input logic [2:0] exp_pos, input int exp_wraps);
        tests++;
        assert (led === exp_led) else begin
            fails++;
            $error("[TB] FAIL %s led: got %b expected %b", tag, led, exp_led);
        end
        tests++;
        assert (pos === exp_pos) else begin
            fails++;
            $error("[TB] FAIL %s pos: got %0d expected %0d", tag, pos, exp_pos);
        end
        tests++;
        assert ((wrap_total - wrap_base) === exp_wraps) else begin
            fails++;
            $error("[TB] FAIL %s wraps: got %0d expected %0d", tag, wrap_total - wrap_base, exp_wraps);
        end
    endtask

    task automatic tick(input string tag, input logic [4:0] exp_led,
                        input logic [2:0] exp_pos, input int exp_wraps);
        applyStimulus(HOLD, HOLD);
        checkOutput(tag, exp_led, exp_pos, exp_wraps);
    endtask

    initial begin
        rst_n   = 1'b0;
        tick_in = 1'b0;
        enable  = 1'b1;
        mode    = 2'd0;
        dir     = 1'b0;
        repeat (3) @(negedge clk);
        wrap_base = wrap_total;
        checkOutput("reset", 5'b00000, 3'd0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset", 5'b00001, 3'd0, 0);

        $display("[TB] chase up with wrap");
        wrap_base = wrap_total;
        tick("chase_up1", 5'b00010, 3'd1, 0);
        tick("chase_up2", 5'b00100, 3'd2, 0);
        tick("chase_up3", 5'b01000, 3'd3, 0);
        tick("chase_up4", 5'b10000, 3'd4, 0);
        tick("chase_wrap", 5'b00001, 3'd0, 1);
        tick("chase_up6", 5'b00010, 3'd1, 1);

        $display("[TB] chase down and fill");
        dir = 1'b1;
        wrap_base = wrap_total;
        tick("chase_dn0", 5'b00001, 3'd0, 0);
        tick("chase_dn_wrap", 5'b10000, 3'd4, 1);
        mode = 2'd2;
        repeat (2) @(negedge clk);
        checkOutput("fill_render", 5'b11111, 3'd4, 1);
        tick("fill_dn3", 5'b01111, 3'd3, 1);
        tick("fill_dn2", 5'b00111, 3'd2, 1);

        $display("[TB] bounce");
        mode = 2'd0;
        dir  = 1'b0;
        tick("chase_to3", 5'b01000, 3'd3, 1);
        wrap_base = wrap_total;
        mode = 2'd1;
        repeat (2) @(negedge clk);
        dir = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("bounce_entry", 5'b01000, 3'd3, 0);
        tick("bounce4", 5'b10000, 3'd4, 0);
        tick("bounce_turn", 5'b01000, 3'd3, 1);
        tick("bounce2", 5'b00100, 3'd2, 1);
        tick("bounce1", 5'b00010, 3'd1, 1);

        $display("[TB] enable low and off mode");
        wrap_base = wrap_total;
        enable = 1'b0;
        tick("dis_a", 5'b00010, 3'd1, 0);
        tick("dis_b", 5'b00010, 3'd1, 0);
        tick("dis_c", 5'b00010, 3'd1, 0);
        enable = 1'b1;
        mode = 2'd3;
        repeat (2) @(negedge clk);
        checkOutput("off_render", 5'b00000, 3'd1, 0);
        tick("off_a", 5'b00000, 3'd1, 0);
        tick("off_b", 5'b00000, 3'd1, 0);
        tick("off_c", 5'b00000, 3'd1, 0);
        mode = 2'd0;
        dir  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("chase_restore", 5'b00010, 3'd1, 0);

        $display("[TB] latency and mid-run reset");
`ifdef TICK_DEBOUNCE_EN
        tick("lat_step", 5'b00100, 3'd2, 0);
`else
        tick_in = 1'b1;
        @(negedge clk);
        checkOutput("lat_edge1", 5'b00010, 3'd1, 0);
        @(negedge clk);
        checkOutput("lat_edge2", 5'b00010, 3'd1, 0);
        @(negedge clk);
        checkOutput("lat_edge3", 5'b00100, 3'd2, 0);
        tick_in = 1'b0;
        repeat (HOLD) @(negedge clk);
`endif
        tick_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        wrap_base = wrap_total;
        checkOutput("mid_reset", 5'b00000, 3'd0, 0);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("mid_release", 5'b00001, 3'd0, 0);
        tick("post_reset_tick", 5'b00010, 3'd1, 0);

`ifdef TICK_DEBOUNCE_EN
        $display("[TB] debounce filter");
        applyStimulus(10, HOLD);
        checkOutput("glitch_dropped", 5'b00010, 3'd1, 0);
        applyStimulus(20, HOLD);
        checkOutput("long_high_step", 5'b00100, 3'd2, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
